// File: rtl/ic_fill_ctrl.sv
// ic_fill_ctrl: I-cache miss responder for a 16-line x 32 B direct-mapped cache.
// It takes one line miss and fetches the 32 B line as BEATS = 256/BUS_W memory
// beats. It assembles the beats into a 256-bit line and presents that line with
// a single-cycle ic_miss_ack pulse. Only one fill is outstanding at a time.
//
// Optional feature macro: IC_FILL_LINEBUF_EN
//   defined   -> a one-entry last-line buffer answers a repeat miss directly
//                (miss -> ACK, with no memory request)
//   undefined -> every miss goes through the memory request and data phases
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ic_miss            miss request, sampled in IDLE only
//   ic_miss_addr       miss byte address; bits [4:0] are ignored
//   fill_cancel        redirect/flush; drops the fill in progress
//   ic_fill_data       assembled line; beat k sits at [k*BUS_W +: BUS_W]
//   ic_miss_ack        one-cycle pulse; ic_fill_data is valid in this cycle
//   fill_busy          high in every state except IDLE
//   mem_req, mem_addr  line read request and line base address
//   mem_gnt            request accepted (same cycle as mem_req)
//   mem_rvalid         one read beat is on mem_rdata; beats arrive in order
//   mem_rdata          read beat data
module ic_fill_ctrl #(
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  input  logic              fill_cancel,
  output logic [255:0]      ic_fill_data,
  output logic              ic_miss_ack,
  output logic              fill_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BUS_W-1:0]  mem_rdata
);

  localparam int BEATS = 256 / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, ACK} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              drop, drop_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [255:0]      fill_nxt;
  logic [ADDR_W-1:0] line_addr;
  logic              unused_addr_bits;

  assign line_addr        = {ic_miss_addr[ADDR_W-1:5], 5'b0};
  assign unused_addr_bits = ^ic_miss_addr[4:0];

  assign mem_req     = (state == REQ);
  assign ic_miss_ack = (state == ACK);
  assign fill_busy   = (state != IDLE);

`ifdef IC_FILL_LINEBUF_EN
  logic              lb_valid;
  logic [ADDR_W-1:0] lb_addr;
  logic [255:0]      lb_data;
  logic              lb_hit;

  assign lb_hit = lb_valid && (lb_addr == line_addr);

  // A cancel invalidates the buffer even if it coincides with an ACK, so a
  // redirect never leaves a line behind that could be returned stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_valid <= 1'b0;
      lb_addr  <= '0;
      lb_data  <= '0;
    end else if (fill_cancel) begin
      lb_valid <= 1'b0;
    end else if (state == ACK) begin
      lb_valid <= 1'b1;
      lb_addr  <= mem_addr;
      lb_data  <= ic_fill_data;
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    drop_nxt     = drop;
    mem_addr_nxt = mem_addr;
    fill_nxt     = ic_fill_data;
    unique case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        drop_nxt     = 1'b0;
        if (ic_miss && !fill_cancel) begin
          mem_addr_nxt = line_addr;
`ifdef IC_FILL_LINEBUF_EN
          if (lb_hit) begin
            fill_nxt  = lb_data;
            state_nxt = ACK;
          end else begin
            state_nxt = REQ;
          end
`else
          state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_gnt) begin
          // Once granted, the beats will come, so a cancel here only marks
          // the fill as dropped instead of abandoning the bus transfer.
          state_nxt    = DATA;
          beat_cnt_nxt = '0;
          drop_nxt     = fill_cancel;
        end else if (fill_cancel) begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (fill_cancel) drop_nxt = 1'b1;
        if (mem_rvalid) begin
          fill_nxt[int'(beat_cnt) * BUS_W +: BUS_W] = mem_rdata;
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            if (drop || fill_cancel) begin
              state_nxt = IDLE;
              drop_nxt  = 1'b0;
            end else begin
              state_nxt = ACK;
            end
          end
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      drop         <= 1'b0;
      mem_addr     <= '0;
      ic_fill_data <= '0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      drop         <= drop_nxt;
      mem_addr     <= mem_addr_nxt;
      ic_fill_data <= fill_nxt;
    end
  end

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Testbench for ic_fill_ctrl (BUS_W=64, ADDR_W=15): directed cases followed by
// randomized fills, checked against a transaction-level reference model.
module tb_ic_fill_ctrl;
  localparam int BUS_W  = 64;
  localparam int ADDR_W = 15;
  localparam int BEATS  = 256 / BUS_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_miss;
  logic [ADDR_W-1:0] ic_miss_addr;
  logic              fill_cancel;
  logic [255:0]      ic_fill_data;
  logic              ic_miss_ack;
  logic              fill_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [BUS_W-1:0]  mem_rdata;

  ic_fill_ctrl #(.BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .fill_cancel(fill_cancel), .ic_fill_data(ic_fill_data), .ic_miss_ack(ic_miss_ack),
    .fill_busy(fill_busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: last committed line and the last-line buffer
  logic [255:0]      last_line;
  logic              lb_valid;
  logic [ADDR_W-1:0] lb_addr;
  logic [255:0]      lb_line;
  logic [ADDR_W-1:0] prev_addr;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 cancel in REQ without grant, 2 cancel with grant,
  //       3 cancel in DATA on beat cbeat. gapv holds 2-bit idle gaps before each beat.
  task automatic do_fill(input logic [ADDR_W-1:0] addr, input int gnt_dly, input int mode,
                         input int cbeat, input logic [7:0] gapv, input logic [63:0] base,
                         input bit rnd_data);
    logic [BUS_W-1:0]  beats [BEATS];
    logic [255:0]      exp_line;
    logic [ADDR_W-1:0] line;
    bit                hit;
    line = {addr[ADDR_W-1:5], 5'b0};
    for (int k = 0; k < BEATS; k++) begin
      beats[k] = rnd_data ? {$urandom, $urandom} : base + 64'(k);
      exp_line[k*BUS_W +: BUS_W] = beats[k];
    end
    hit = 1'b0;
`ifdef IC_FILL_LINEBUF_EN
    hit = lb_valid && (lb_addr == line);
`endif
    prev_addr    = addr;
    ic_miss      = 1'b1;
    ic_miss_addr = addr;
    tick();
    // miss and address are noise from here on; the DUT must ignore them
    ic_miss      = 1'($urandom_range(0, 1));
    ic_miss_addr = ADDR_W'($urandom);
    if (hit) begin
      chk("lb_ack", 256'(ic_miss_ack), 256'd1);
      chk("lb_no_req", 256'(mem_req), 256'd0);
      chk("lb_data", ic_fill_data, lb_line);
      tick();
      ic_miss = 1'b0;
      chk("lb_ack_end", 256'(ic_miss_ack), 256'd0);
      last_line = lb_line;
      return;
    end
    chk("req_up", 256'(mem_req), 256'd1);
    chk("req_addr", 256'(mem_addr), 256'(line));
    chk("busy_req", 256'(fill_busy), 256'd1);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      chk("req_held", 256'(mem_req), 256'd1);
      chk("addr_held", 256'(mem_addr), 256'(line));
    end
    if (mode == 1) begin
      fill_cancel = 1'b1;
      tick();
      fill_cancel = 1'b0;
      ic_miss     = 1'b0;
      lb_valid    = 1'b0;
      chk("cancel_req_drop", 256'(mem_req), 256'd0);
      chk("cancel_req_idle", 256'(fill_busy), 256'd0);
      return;
    end
    mem_gnt     = 1'b1;
    fill_cancel = (mode == 2);
    tick();
    mem_gnt     = 1'b0;
    fill_cancel = 1'b0;
    if (mode == 2) lb_valid = 1'b0;
    chk("req_after_gnt", 256'(mem_req), 256'd0);
    for (int k = 0; k < BEATS; k++) begin
      for (int g = 0; g < int'(gapv[2*k +: 2]); g++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
        tick();
        chk("ack_early_gap", 256'(ic_miss_ack), 256'd0);
      end
      mem_rvalid  = 1'b1;
      mem_rdata   = beats[k];
      fill_cancel = (mode == 3) && (k == cbeat);
      tick();
      mem_rvalid  = 1'b0;
      fill_cancel = 1'b0;
      if ((mode == 3) && (k == cbeat)) lb_valid = 1'b0;
      if (k < BEATS - 1) begin
        chk("ack_early_beat", 256'(ic_miss_ack), 256'd0);
        chk("busy_data", 256'(fill_busy), 256'd1);
      end
    end
    if (mode >= 2) begin
      ic_miss = 1'b0;
      chk("drop_no_ack", 256'(ic_miss_ack), 256'd0);
      chk("drop_idle", 256'(fill_busy), 256'd0);
      return;
    end
    chk("ack_pulse", 256'(ic_miss_ack), 256'd1);
    chk("ack_data", ic_fill_data, exp_line);
    tick();
    ic_miss = 1'b0;
    chk("ack_one_cycle", 256'(ic_miss_ack), 256'd0);
    chk("idle_after_ack", 256'(fill_busy), 256'd0);
    chk("data_hold", ic_fill_data, exp_line);
    last_line = exp_line;
    lb_valid  = 1'b1;
    lb_addr   = line;
    lb_line   = exp_line;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int                mode;
    rst          = 1'b1;
    ic_miss      = 1'b0;
    ic_miss_addr = '0;
    fill_cancel  = 1'b0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    last_line    = '0;
    lb_valid     = 1'b0;
    lb_addr      = '0;
    lb_line      = '0;
    prev_addr    = '0;
    #12;
    chk("rst_ack", 256'(ic_miss_ack), 256'd0);
    chk("rst_data", ic_fill_data, 256'd0);
    chk("rst_req", 256'(mem_req), 256'd0);
    chk("rst_addr", 256'(mem_addr), 256'd0);
    chk("rst_busy", 256'(fill_busy), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // basic fill: grant at once, back-to-back beats; ack lands 6 cycles after the miss
    do_fill(15'h1234, 0, 0, 0, 8'h00, 64'hA0, 1'b0);
    chk("basic_line", last_line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

    // rvalid in IDLE must not disturb the held line
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = {$urandom, $urandom};
      tick();
      chk("idle_rvalid_data", ic_fill_data, last_line);
      chk("idle_rvalid_busy", 256'(fill_busy), 256'd0);
    end
    mem_rvalid = 1'b0;

    // late grant and gapped beats: rvalid pattern 1,0,1,1,0,1
    do_fill(15'h2468, 3, 0, 0, 8'b01_00_01_00, 64'hB0, 1'b0);
    // cancel on beat 2, then a clean fill to 0x0040
    do_fill(15'h3300, 0, 3, 2, 8'h00, 64'hC0, 1'b0);
    do_fill(15'h0040, 0, 0, 0, 8'h00, 64'hD0, 1'b0);
    // cancel in REQ before grant; cancel together with grant
    do_fill(15'h0100, 1, 1, 0, 8'h00, 64'hE0, 1'b0);
    do_fill(15'h0200, 0, 2, 0, 8'h00, 64'hF0, 1'b0);

    // asynchronous reset in DATA after beat 1
    ic_miss      = 1'b1;
    ic_miss_addr = 15'h5555;
    tick();
    ic_miss = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h99 + 64'(k);
      tick();
    end
    mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_ack", 256'(ic_miss_ack), 256'd0);
    chk("arst_data", ic_fill_data, 256'd0);
    chk("arst_req", 256'(mem_req), 256'd0);
    chk("arst_addr", 256'(mem_addr), 256'd0);
    chk("arst_busy", 256'(fill_busy), 256'd0);
    @(negedge clk);
    rst       = 1'b0;
    lb_valid  = 1'b0;
    last_line = '0;
    tick();
    do_fill(15'h5555, 0, 0, 0, 8'h00, 64'h10, 1'b0);

    // repeat miss: answered from the line buffer when present, else refetched
    do_fill(15'h7FE0, 0, 0, 0, 8'h00, 64'h70, 1'b0);
    do_fill(15'h7FE0, 0, 0, 0, 8'h00, 64'h80, 1'b0);

    // randomized fills
    for (int it = 0; it < 40; it++) begin
      a    = ($urandom_range(0, 3) == 0) ? prev_addr : ADDR_W'($urandom);
      mode = $urandom_range(0, 6);
      if (mode > 3) mode = 0;
      do_fill(a, $urandom_range(0, 3), mode, $urandom_range(0, BEATS - 1),
              8'($urandom), 64'h0, 1'b1);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
